sba_initiator: RTL
==================

Name: sba_initiator

Overview:
- Debug-side system bus initiator. Takes single-access commands from the debug module's system bus access registers and drives them onto the arilla bus.
- Claims bus ownership from rv_core through the intercept handshake, performs one read or write per command, then releases the bus.
- Returns right-justified read data, error status and an auto-incremented address to the debug module.

Parameters:
- AddrWidth, 32, bus address width.
- DataWidth, 32, bus data width; fixed at 32 (4 byte lanes).
- TimeoutCycles, 255, maximum cycles in ACCESS before the access aborts with a timeout error.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE with sticky error clear.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  AddrWidth  byte address.
- cmd_wdata  input  32  write data, right-justified.
- cmd_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- cmd_autoinc  input  1  increment address after a successful access.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  right-justified, zero-extended read data.
- rsp_addr  output  AddrWidth  next address (incremented if autoinc and OK).
- sb_error  output  3  sticky: 0 none, 1 timeout, 3 alignment, 4 size.
- err_clear  input  1  clears sb_error.
- busy  output  1  high from command accept until rsp_valid.
- bus_intercept  output  1  claims the bus from the core.
- bus_available  input  1  bus free for the interceptor this cycle.
- bus_address  output  AddrWidth  word-aligned address.
- bus_data_out  output  32  lane-replicated write data.
- bus_data_in  input  32  read data, valid with bus_done.
- bus_read  output  1  read strobe.
- bus_write  output  1  write strobe.
- bus_byte_enable  output  4  active lanes.
- bus_done  input  1  responder completion.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset mid-access drops intercept and strobes on the next edge; no response is issued.
- States:
  - IDLE:
    - cmd_ready = (sb_error == 0).
    - On cmd_valid && cmd_ready, latch the command, set busy, go to CHECK.
    - cmd_valid while sb_error != 0 is ignored.
  - CHECK (1 cycle):
    - size == 3 → error 4.
    - Misaligned (half with addr[0] set, word with addr[1:0] != 0) → error 3.
    - On either error, go to RESP with no bus activity. Otherwise go to GRANT.
  - GRANT:
    - Assert bus_intercept; hold address, data and byte enables stable.
    - Wait for bus_available; on the first cycle it is high, go to ACCESS.
    - No timeout in GRANT.
  - ACCESS:
    - Assert bus_read or bus_write (exactly one) and keep bus_intercept high; the timeout counter runs.
    - bus_done → capture data, go to RESP.
    - Counter reaches TimeoutCycles without bus_done → error 1, go to RESP.
    - bus_done on the same cycle as counter expiry: bus_done wins.
    - If bus_available drops during ACCESS, hold strobes and wait.
  - RESP (1 cycle):
    - Deassert intercept and strobes; pulse rsp_valid; update rsp_rdata and rsp_addr; clear busy; return to IDLE.
- Lane rules:
  - bus_address = {addr[AW-1:2], 2'b00}.
  - byte_enable = 0001 << addr[1:0] (byte), 0011 << addr[1:0] (half), 1111 (word).
  - Write data is replicated into every lane.
  - Read data is shifted right by 8*addr[1:0] and masked to size.
- Auto-increment:
  - rsp_addr = addr + (1 << size), modulo 2^AddrWidth (0xFFFFFFFC + 4 → 0).
  - Applied only when no error; on error rsp_addr = addr.
- sb_error latches the first nonzero code and holds it. err_clear zeroes it in any state; a same-cycle new error wins over the clear.
- Minimum latency, command accept to rsp_valid with bus_available and bus_done both immediate: 4 cycles.

Decomposition:
- Package sba_pkg: state enum, size codes, error codes (SbaErrNone/Timeout/Align/Size), lane-mask and extract functions.
- One sub-module, sba_lane_align: combinational byte-enable generation, write replication and read extraction.
- The FSM and timeout counter live in sba_initiator.

Test Plan:
- Word write 0xDEADBEEF to 0x100, bus available, memory done after 1 cycle → byte_enable 1111, bus_data_out DEADBEEF, rsp_valid with error 0, rsp_addr 0x104 when autoinc is set.
- Byte read from 0x103 with memory word 0x11223344 → bus_address 0x100, byte_enable 1000, rsp_rdata 0x00000011.
- Half read at 0x101 → no bus strobes, error 3, cmd_ready low until err_clear, rsp_addr 0x101.
- bus_available held low for 20 cycles → intercept high throughout, no strobe; when available rises the access completes normally.
- bus_done never asserted → rsp_valid exactly TimeoutCycles+1 cycles after entering ACCESS, error 1, strobes and intercept low afterwards.
- rst asserted during ACCESS → next cycle all outputs 0, no rsp_valid; a new command after reset completes normally.

Source files
------------

// File: rtl/sba_pkg.sv
// rtl/sba_pkg.sv - shared types, codes and lane helpers for the system bus initiator
//
// Contents:
//   sba_state_e    initiator FSM states
//   SbaSize*       cmd_size encodings
//   SbaErr*        sb_error codes
//   lane_mask      byte-enable pattern for a size/offset pair
//   replicate      copy right-justified write data into every lane
//   extract        right-justify and zero-extend a read word
//   is_misaligned  natural-alignment check for half and word accesses
package sba_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_GRANT,
        ST_ACCESS,
        ST_RESP
    } sba_state_e;

    localparam logic [1:0] SbaSizeByte = 2'd0;
    localparam logic [1:0] SbaSizeHalf = 2'd1;
    localparam logic [1:0] SbaSizeWord = 2'd2;
    localparam logic [1:0] SbaSizeBad  = 2'd3;

    localparam logic [2:0] SbaErrNone    = 3'd0;
    localparam logic [2:0] SbaErrTimeout = 3'd1;
    localparam logic [2:0] SbaErrAlign   = 3'd3;
    localparam logic [2:0] SbaErrSize    = 3'd4;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SbaSizeByte: lane_mask = 4'b0001 << offset;
            SbaSizeHalf: lane_mask = 4'b0011 << offset;
            default:     lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [31:0] data, input logic [1:0] size);
        case (size)
            SbaSizeByte: replicate = {4{data[7:0]}};
            SbaSizeHalf: replicate = {2{data[15:0]}};
            default:     replicate = data;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] offset);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (size)
            SbaSizeByte: extract = {24'h0, shifted[7:0]};
            SbaSizeHalf: extract = {16'h0, shifted[15:0]};
            default:     extract = shifted;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SbaSizeHalf: is_misaligned = offset[0];
            SbaSizeWord: is_misaligned = (offset != 2'b00);
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sba_lane_align.sv
// rtl/sba_lane_align.sv - byte-lane steering between right-justified data and the 32-bit bus
//
// Ports:
//   size, offset  access size code and byte offset within the word
//   wdata         right-justified write data
//   bus_rdata     raw word from the bus
//   byte_enable   active lanes for this access
//   bus_wdata     write data replicated into every lane
//   rdata         read data shifted down and masked to size
module sba_lane_align
    import sba_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] bus_wdata,
    output logic [31:0] rdata
);

    assign byte_enable = lane_mask(size, offset);
    assign bus_wdata   = replicate(wdata, size);
    assign rdata       = extract(bus_rdata, size, offset);

endmodule

// File: rtl/sba_initiator.sv
// rtl/sba_initiator.sv - debug-side single-access system bus initiator
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_*                    command from the debug module (valid/ready handshake)
//   rsp_valid/rdata/addr     one-cycle completion with read data and next address
//   sb_error, err_clear      sticky error code and its clear
//   busy                     command in flight
//   bus_intercept            claim on the bus against the core
//   bus_available            bus granted to the interceptor this cycle
//   bus_address/data_out     word address and lane-replicated write data
//   bus_read/write           access strobes
//   bus_byte_enable          active lanes
//   bus_data_in, bus_done    responder read data and completion
module sba_initiator
    import sba_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [AddrWidth-1:0] cmd_addr,
    input  logic [DataWidth-1:0] cmd_wdata,
    input  logic [1:0]           cmd_size,
    input  logic                 cmd_autoinc,
    output logic                 rsp_valid,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic [AddrWidth-1:0] rsp_addr,
    output logic [2:0]           sb_error,
    input  logic                 err_clear,
    output logic                 busy,
    output logic                 bus_intercept,
    input  logic                 bus_available,
    output logic [AddrWidth-1:0] bus_address,
    output logic [DataWidth-1:0] bus_data_out,
    input  logic [DataWidth-1:0] bus_data_in,
    output logic                 bus_read,
    output logic                 bus_write,
    output logic [3:0]           bus_byte_enable,
    input  logic                 bus_done
);

    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TimeoutCycles);

    sba_state_e           state;
    logic                 write_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [1:0]           size_q;
    logic                 autoinc_q;
    logic [CntW-1:0]      cnt;

    logic [3:0]           lane_be;
    logic [DataWidth-1:0] lane_wdata;
    logic [DataWidth-1:0] lane_rdata;
    logic [AddrWidth-1:0] next_addr;
    logic                 access_done;
    logic [2:0]           new_err;
    logic [2:0]           err_next;

    sba_lane_align u_lane_align (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .wdata       (wdata_q),
        .bus_rdata   (bus_data_in),
        .byte_enable (lane_be),
        .bus_wdata   (lane_wdata),
        .rdata       (lane_rdata)
    );

    // A completion only counts while the bus is actually ours; if availability
    // drops mid-access the strobes are held and we keep waiting.
    assign access_done = bus_done && bus_available;
    assign next_addr   = autoinc_q ? addr_q + (AddrWidth'(1) << size_q) : addr_q;

    // Error raised this cycle, and the sticky register's next value: the first
    // nonzero code sticks, and a fresh error beats a simultaneous clear.
    always_comb begin
        new_err = SbaErrNone;
        if (state == ST_CHECK) begin
            if (size_q == SbaSizeBad) begin
                new_err = SbaErrSize;
            end else if (is_misaligned(size_q, addr_q[1:0])) begin
                new_err = SbaErrAlign;
            end
        end else if (state == ST_ACCESS && !access_done && cnt == TimeoutCnt) begin
            new_err = SbaErrTimeout;
        end

        err_next = sb_error;
        if (new_err != SbaErrNone && (sb_error == SbaErrNone || err_clear)) begin
            err_next = new_err;
        end else if (err_clear) begin
            err_next = SbaErrNone;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            write_q         <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            size_q          <= 2'b00;
            autoinc_q       <= 1'b0;
            cnt             <= '0;
            cmd_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_addr        <= '0;
            sb_error        <= SbaErrNone;
            busy            <= 1'b0;
            bus_intercept   <= 1'b0;
            bus_address     <= '0;
            bus_data_out    <= '0;
            bus_read        <= 1'b0;
            bus_write       <= 1'b0;
            bus_byte_enable <= 4'b0000;
        end else begin
            sb_error  <= err_next;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        write_q   <= cmd_write;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        size_q    <= cmd_size;
                        autoinc_q <= cmd_autoinc;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= ST_CHECK;
                    end else begin
                        cmd_ready <= (err_next == SbaErrNone);
                    end
                end
                ST_CHECK: begin
                    if (new_err != SbaErrNone) begin
                        rsp_rdata <= '0;
                        rsp_addr  <= addr_q;
                        rsp_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        // Address, lanes and data are set up with the claim
                        // and stay put until the access completes.
                        bus_intercept   <= 1'b1;
                        bus_address     <= {addr_q[AddrWidth-1:2], 2'b00};
                        bus_byte_enable <= lane_be;
                        bus_data_out    <= lane_wdata;
                        state           <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (bus_available) begin
                        bus_read  <= !write_q;
                        bus_write <= write_q;
                        cnt       <= '0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (access_done || cnt == TimeoutCnt) begin
                        rsp_rdata       <= (access_done && !write_q) ? lane_rdata : '0;
                        rsp_addr        <= access_done ? next_addr : addr_q;
                        rsp_valid       <= 1'b1;
                        busy            <= 1'b0;
                        bus_intercept   <= 1'b0;
                        bus_read        <= 1'b0;
                        bus_write       <= 1'b0;
                        bus_address     <= '0;
                        bus_data_out    <= '0;
                        bus_byte_enable <= 4'b0000;
                        state           <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    cmd_ready <= (err_next == SbaErrNone);
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
